top_level: RTL and testbench

//  Self-contained LFSR stream decryptor. Ciphertext is preloaded into data memory at 64..127.
//  The block recovers the LFSR tap pattern and seed from the known space-padded preamble,

---
 rtl/decrypt_pkg.sv | 22 ++
 rtl/data_mem.sv | 16 +
 rtl/top_level.sv | 119 +++++++++++
 tb/tb_top_level.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// Shared constants, tap table, FSM state encoding and LFSR step for the stream decryptor.
package decrypt_pkg;
   localparam logic [7:0] SPACE    = 8'h20;
   localparam logic [7:0] SRC_BASE = 8'd64;
   localparam int         MSG_LEN  = 64;
   localparam int         OUT_LEN  = 55;
   localparam int         PRE_CHK  = 9;

   localparam logic [5:0] SRC_LAST = 6'(MSG_LEN - 1);
   localparam logic [5:0] OUT_LAST = 6'(OUT_LEN - 1);
   localparam logic [3:0] CHK_LAST = 4'(PRE_CHK - 1);

   localparam logic [7:0] TAPS [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_TRY, S_SKIP, S_COPY_RD, S_COPY_WR, S_PAD, S_DONE
   } state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] taps);
      return {s[6:0], ^(s & taps)};
   endfunction
endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, synchronous write, single shared address.
module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);
   logic [7:0] core [256];

   assign rdata = core[addr];

   always_ff @(posedge clk) begin
      if (we) core[addr] <= wdata;
   end
endmodule

// File: rtl/top_level.sv
// LFSR stream decryptor: recovers taps/seed from the space preamble, strips leading
// spaces and writes the plaintext to 0..OUT_LEN-1, space padded.
module top_level
   import decrypt_pkg::*;
(
   input  logic clk,
   input  logic init,
   output logic done
);
   state_t     state;
   logic [7:0] seed, lfsr, pt;
   logic [2:0] tap_idx;
   logic [3:0] k;
   logic [5:0] i, j;
   logic [7:0] addr, wdata, rdata, lfsr_nxt;
   logic       we;

   assign lfsr_nxt = lfsr_step(lfsr, TAPS[tap_idx]);

   // One memory access per cycle, so a copied byte takes a read cycle and a write cycle.
   always_comb begin
      addr  = SRC_BASE;
      we    = 1'b0;
      wdata = SPACE;
      case (state)
         S_TRY:             addr = SRC_BASE + {4'd0, k};
         S_SKIP, S_COPY_RD: addr = SRC_BASE + {2'd0, i};
         S_COPY_WR: begin addr = {2'd0, j}; we = 1'b1; wdata = pt; end
         S_PAD:     begin addr = {2'd0, j}; we = 1'b1; end
         default: ;
      endcase
   end

   data_mem dm1 (.clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata));

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state   <= S_IDLE;
         done    <= 1'b0;
         seed    <= '0;
         lfsr    <= '0;
         pt      <= '0;
         tap_idx <= '0;
         k       <= '0;
         i       <= '0;
         j       <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_SEED;
            S_SEED: begin
               seed    <= rdata ^ SPACE;
               lfsr    <= rdata ^ SPACE;
               tap_idx <= '0;
               k       <= 4'd1;
               state   <= S_TRY;
            end
            S_TRY: begin
               if ((rdata ^ lfsr_nxt) != SPACE) begin
                  lfsr <= seed;
                  k    <= 4'd1;
                  // No candidate matched: fall back to tap 0 and still finish.
                  if (tap_idx == 3'd7) begin
                     tap_idx <= '0;
                     i       <= '0;
                     state   <= S_SKIP;
                  end else begin
                     tap_idx <= tap_idx + 3'd1;
                  end
               end else if (k == CHK_LAST) begin
                  lfsr  <= seed;
                  i     <= '0;
                  state <= S_SKIP;
               end else begin
                  lfsr <= lfsr_nxt;
                  k    <= k + 4'd1;
               end
            end
            S_SKIP: begin
               if ((rdata ^ lfsr) == SPACE) begin
                  lfsr <= lfsr_nxt;
                  if (i == SRC_LAST) begin
                     j     <= '0;
                     state <= S_PAD;
                  end else begin
                     i <= i + 6'd1;
                  end
               end else begin
                  pt    <= rdata ^ lfsr;
                  state <= S_COPY_WR;
               end
            end
            S_COPY_RD: begin
               pt    <= rdata ^ lfsr;
               state <= S_COPY_WR;
            end
            S_COPY_WR: begin
               if (j == OUT_LAST) begin
                  state <= S_DONE;
               end else begin
                  j <= j + 6'd1;
                  if (i == SRC_LAST) begin
                     state <= S_PAD;
                  end else begin
                     i     <= i + 6'd1;
                     lfsr  <= lfsr_nxt;
                     state <= S_COPY_RD;
                  end
               end
            end
            S_PAD: begin
               if (j == OUT_LAST) state <= S_DONE;
               else               j     <= j + 6'd1;
            end
            S_DONE: done <= 1'b1;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the LFSR stream decryptor: preloads ciphertext, runs, checks plaintext.
module tb_top_level;
   import decrypt_pkg::*;

   logic clk = 1'b0;
   logic init = 1'b1;
   logic done;
   int   errors = 0;
   int   checks = 0;

   logic [7:0]        snap [128];
   logic [55*8-1:0]   got, exp_v;
   bit                ok;
   int                diffs;

   localparam logic [7:0] TAP_TBL [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};
   localparam string MSG1 = "  01234546789abcdefghijklmnopqrstuvwxyz. ";
   localparam string EXP1 = "01234546789abcdefghijklmnopqrstuvwxyz. ";
   localparam string MSG2 = "Mr. Watson, come here. I want to see you.";

   top_level dut (.clk(clk), .init(init), .done(done));

   always #5 clk = ~clk;

   function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
      return {s[6:0], ^(s & t)};
   endfunction

   // Encrypts pre spaces + msg (space filled to 64) into 64..127; clears output area.
   task automatic load(input string msg, input int pre, input logic [7:0] t, input logic [7:0] seed);
      logic [7:0] s, p;
      s = seed;
      for (int n = 0; n < 64; n++) begin
         if (n < pre || n - pre >= msg.len()) p = 8'h20;
         else p = msg[n - pre];
         dut.dm1.core[64 + n] = p ^ s;
         s = step(s, t);
      end
      for (int n = 0; n < 64; n++) dut.dm1.core[n] = 8'h00;
   endtask

   function automatic logic [55*8-1:0] expect_str(input string e);
      logic [55*8-1:0] v;
      for (int n = 0; n < 55; n++) v[n*8 +: 8] = (n < e.len()) ? e[n] : 8'h20;
      return v;
   endfunction

   task automatic read_out(output logic [55*8-1:0] v);
      for (int n = 0; n < 55; n++) v[n*8 +: 8] = dut.dm1.core[n];
   endtask

   task automatic take_snap();
      for (int n = 0; n < 128; n++) snap[n] = dut.dm1.core[n];
   endtask

   task automatic count_diffs(output int d);
      d = 0;
      for (int n = 0; n < 128; n++) if (dut.dm1.core[n] !== snap[n]) d++;
   endtask

   task automatic run_wait(output bit fin);
      fin = 1'b0;
      @(negedge clk) init = 1'b0;
      for (int c = 0; c < 1000 && !fin; c++) begin
         @(negedge clk);
         if (done === 1'b1) fin = 1'b1;
      end
   endtask

   task automatic reset_cycles(input int n);
      @(negedge clk) init = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_run(input string tag, input logic [55*8-1:0] e);
      run_wait(ok);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s_done: observed done=%0b required 1 within 1000 cycles", tag, done);
      end
      read_out(got);
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL %s_out: observed %h required %h", tag, got, e);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checks++;
      assert (done === 1'b0) else begin
         errors++;
         $error("FAIL reset_done: observed %0b required 0", done);
      end

      load(MSG1, 12, 8'hf3, 8'h01);
      check_run("msg1_f3", expect_str(EXP1));

      for (int t = 0; t < 8; t++) begin
         reset_cycles(2);
         load(MSG1, 12, TAP_TBL[t], 8'ha5);
         check_run($sformatf("taps%0d", t), expect_str(EXP1));
      end

      reset_cycles(2);
      load(MSG2, 9, 8'he1, 8'hff);
      check_run("watson", expect_str(MSG2));

      reset_cycles(2);
      load("", 64, 8'hb4, 8'h3c);
      check_run("allspace", expect_str(""));

      // Abort in the middle of the copy phase, then rerun.
      reset_cycles(2);
      load(MSG1, 12, 8'hf3, 8'h01);
      @(negedge clk) init = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (dut.state == S_COPY_WR) ok = 1'b1;
      end
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL abort_reach_copy: observed no copy phase, required within 400 cycles");
      end
      repeat (6) @(negedge clk);
      take_snap();
      init = 1'b1;
      #1;
      checks++;
      assert (done === 1'b0) else begin
         errors++;
         $error("FAIL abort_done: observed %0b required 0", done);
      end
      repeat (3) @(negedge clk);
      count_diffs(diffs);
      checks++;
      assert (diffs === 0) else begin
         errors++;
         $error("FAIL abort_nowrite: observed %0d changed bytes required 0", diffs);
      end
      check_run("rerun", expect_str(EXP1));

      // Completion is sticky and memory stays frozen.
      take_snap();
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (done !== 1'b1) ok = 1'b0;
      end
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL hold_done: observed done dropped, required 1 for 100 cycles");
      end
      count_diffs(diffs);
      checks++;
      assert (diffs === 0) else begin
         errors++;
         $error("FAIL hold_mem: observed %0d changed bytes required 0", diffs);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
